// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external dual-port RAM (A = write, B = read).
// A 2-entry skid register absorbs the RAM's 1-cycle read latency for first-word-fall-through output.
module ram_fifo_ctrl #(
    parameter int data_wd = 48,
    parameter int add_wd  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [data_wd-1:0] wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [data_wd-1:0] rd_data,
    output logic [add_wd+1:0]  level,
    output logic               cs_a,
    output logic               rnw_a,
    output logic [add_wd-1:0]  a_add,
    output logic [data_wd-1:0] a_data_in,
    output logic               cs_b,
    output logic               rnw_b,
    output logic [add_wd-1:0]  b_add,
    input  logic [data_wd-1:0] b_data_out
);

    localparam int DEPTH = 1 << add_wd;
    localparam logic [add_wd:0]   MEM_FULL = (add_wd+1)'(DEPTH);
    localparam logic [add_wd-1:0] PTR_ONE  = add_wd'(1);

    logic [add_wd-1:0]  wr_ptr;
    logic [add_wd-1:0]  rd_ptr;
    logic [add_wd:0]    mem_cnt;
    logic               inflight;
    logic [data_wd-1:0] skid [2];
    logic [1:0]         out_cnt;
    logic               head;
    logic               tail;
    logic               push;
    logic               pop;
    logic               issue;
    logic [2:0]         occ_after_pop;

    assign wr_ready = rst_n && (mem_cnt != MEM_FULL);
    assign push     = wr_valid && wr_ready;
    assign rd_valid = (out_cnt != 2'd0);
    assign rd_data  = skid[head];
    assign pop      = rd_valid && rd_ready;

    // Only issue a read if the skid will have a free slot when its data lands.
    assign occ_after_pop = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue         = rst_n && (mem_cnt != '0) && (occ_after_pop < 3'd2);

    assign cs_a      = push;
    assign rnw_a     = 1'b0;
    assign a_add     = wr_ptr;
    assign a_data_in = wr_data;
    assign cs_b      = issue;
    assign rnw_b     = 1'b1;
    assign b_add     = rd_ptr;

    assign level = (add_wd+2)'(mem_cnt) + (add_wd+2)'(inflight) + (add_wd+2)'(out_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            skid[0]  <= '0;
            skid[1]  <= '0;
            out_cnt  <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (issue)
                rd_ptr <= rd_ptr + PTR_ONE;
            mem_cnt  <= mem_cnt + (add_wd+1)'(push) - (add_wd+1)'(issue);
            inflight <= issue;
            if (inflight) begin
                skid[tail] <= b_data_out;
                tail       <= ~tail;
            end
            if (pop)
                head <= ~head;
            out_cnt <= out_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
